// File: rtl/wavepool_issue_arbiter_if.sv
// Wavepool-to-decode arbitration bus: requests, decode handshake, release/recover
// inputs and the presented wfid with its pop strobe and in-flight state.
interface wavepool_issue_arbiter_if #(
   parameter int unsigned NUM_WF = 40,
   parameter int unsigned WFID_W = 6
);
   logic [NUM_WF-1:0] wf_req;
   logic              decode_ready;
   logic              release_en;
   logic [WFID_W-1:0] release_wfid;
   logic              issue_recover_en;
   logic [WFID_W-1:0] issue_recover_wfid;
   logic              arb_valid;
   logic [WFID_W-1:0] arb_wfid;
   logic [NUM_WF-1:0] wf_pop;
   logic [NUM_WF-1:0] inflight_mask;
   logic [31:0]       stall_cnt;

   modport master (
      output wf_req, decode_ready, release_en, release_wfid, issue_recover_en,
             issue_recover_wfid,
      input  arb_valid, arb_wfid, wf_pop, inflight_mask, stall_cnt
   );

   modport slave (
      input  wf_req, decode_ready, release_en, release_wfid, issue_recover_en,
             issue_recover_wfid,
      output arb_valid, arb_wfid, wf_pop, inflight_mask, stall_cnt
   );
endinterface

// File: rtl/wavepool_issue_arbiter.sv
// Round-robin wavefront issue arbiter with one-in-flight tracking and recovery squash.
// Optional decode-backpressure counter enabled by WAVEPOOL_ARB_STALL_CNT_EN.
module wavepool_issue_arbiter #(
   parameter int unsigned NUM_WF = 40,
   parameter int unsigned WFID_W = 6
) (
   input logic                   clk,
   input logic                   rst,
   wavepool_issue_arbiter_if.slave bus
);

   localparam logic [WFID_W-1:0] LastWf = WFID_W'(NUM_WF - 1);

   logic              arb_valid_q;
   logic [WFID_W-1:0] arb_wfid_q;
   logic [WFID_W-1:0] last_wfid_q;
   logic [NUM_WF-1:0] inflight_q;
   logic [NUM_WF-1:0] inflight_d;

   logic              squash;
   logic              pop;
   logic              out_free;
   logic [NUM_WF-1:0] rec_mask;
   logic [NUM_WF-1:0] clr_mask;
   logic [NUM_WF-1:0] pop_vec;
   logic [NUM_WF-1:0] elig;
   logic              pick_found;
   logic [WFID_W-1:0] pick_idx;
   logic [NUM_WF-1:0] pick_vec;

   // Out-of-range wfids never match a slot below, so they are ignored implicitly.
   always_comb begin
      squash   = arb_valid_q && bus.issue_recover_en && (arb_wfid_q == bus.issue_recover_wfid);
      pop      = arb_valid_q && bus.decode_ready && !squash;
      out_free = !arb_valid_q || bus.decode_ready || squash;
      rec_mask = '0;
      clr_mask = '0;
      pop_vec  = '0;
      for (int unsigned i = 0; i < NUM_WF; i++) begin
         if (bus.issue_recover_en && bus.issue_recover_wfid == WFID_W'(i)) rec_mask[i] = 1'b1;
         if (bus.release_en && bus.release_wfid == WFID_W'(i)) clr_mask[i] = 1'b1;
         if (pop && arb_wfid_q == WFID_W'(i)) pop_vec[i] = 1'b1;
      end
      clr_mask = clr_mask | rec_mask;
      elig     = bus.wf_req & ~inflight_q & ~rec_mask;
   end

   // First eligible slot above the pointer, else wrap to the lowest eligible slot.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      pick_vec   = '0;
      for (int unsigned i = 0; i < NUM_WF; i++) begin
         if (!pick_found && elig[i] && (i > 32'(last_wfid_q))) begin
            pick_found  = 1'b1;
            pick_idx    = WFID_W'(i);
            pick_vec[i] = 1'b1;
         end
      end
      for (int unsigned i = 0; i < NUM_WF; i++) begin
         if (!pick_found && elig[i]) begin
            pick_found  = 1'b1;
            pick_idx    = WFID_W'(i);
            pick_vec[i] = 1'b1;
         end
      end
   end

   always_comb begin
      inflight_d = inflight_q & ~clr_mask;
      if (out_free && pick_found) inflight_d = inflight_d | pick_vec;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         arb_valid_q <= 1'b0;
         arb_wfid_q  <= '0;
         last_wfid_q <= LastWf;
         inflight_q  <= '0;
      end else begin
         inflight_q <= inflight_d;
         if (out_free) begin
            arb_valid_q <= pick_found;
            if (pick_found) begin
               arb_wfid_q  <= pick_idx;
               last_wfid_q <= pick_idx;
            end
         end
      end
   end

   assign bus.arb_valid     = arb_valid_q;
   assign bus.arb_wfid      = arb_wfid_q;
   assign bus.wf_pop        = pop_vec;
   assign bus.inflight_mask = inflight_q;

`ifdef WAVEPOOL_ARB_STALL_CNT_EN
   logic [31:0] stall_cnt_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt_q <= '0;
      end else if (arb_valid_q && !bus.decode_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
         stall_cnt_q <= stall_cnt_q + 32'd1;
      end
   end

   assign bus.stall_cnt = stall_cnt_q;
`else
   assign bus.stall_cnt = '0;
`endif

endmodule

// File: tb/tb_wavepool_issue_arbiter.sv
// Directed bench for wavepool_issue_arbiter; pops are scored against an expected-grant queue.
module tb_wavepool_issue_arbiter;

   localparam int unsigned NumWf  = 40;
   localparam int unsigned WfidW  = 6;
`ifdef WAVEPOOL_ARB_STALL_CNT_EN
   localparam bit StallEn = 1'b1;
`else
   localparam bit StallEn = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   wavepool_issue_arbiter_if #(.NUM_WF(NumWf), .WFID_W(WfidW)) bus ();

   wavepool_issue_arbiter #(.NUM_WF(NumWf), .WFID_W(WfidW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int          checks = 0;
   int          errors = 0;
   int unsigned exp_q[$];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Scoreboard: every pop must match the next expected grant.
   always @(negedge clk) begin
      logic [NumWf-1:0] exp_vec;
      int unsigned      w;
      if (|bus.wf_pop) begin
         if (exp_q.size() == 0) begin
            check("pop_unexpected", 64'(bus.wf_pop), 64'd0);
         end else begin
            w = exp_q.pop_front();
            exp_vec = '0;
            exp_vec[w] = 1'b1;
            check("pop_vec", 64'(bus.wf_pop), 64'(exp_vec));
            check("pop_wfid", 64'(bus.arb_wfid), 64'(w));
         end
      end
   end

   task automatic idle_inputs();
      bus.wf_req             = '0;
      bus.decode_ready       = 1'b0;
      bus.release_en         = 1'b0;
      bus.release_wfid       = '0;
      bus.issue_recover_en   = 1'b0;
      bus.issue_recover_wfid = '0;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      idle_inputs();
      #1;
      check("rst_valid", 64'(bus.arb_valid), 64'd0);
      check("rst_wfid", 64'(bus.arb_wfid), 64'd0);
      check("rst_inflight", 64'(bus.inflight_mask), 64'd0);
      check("rst_stall", 64'(bus.stall_cnt), 64'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      next_cycle();
   endtask

   task automatic check_drained(input string tag);
      check(tag, 64'(exp_q.size()), 64'd0);
   endtask

   initial begin
      logic [NumWf-1:0] m;

      // Three sparse requesters, decode always ready.
      do_reset();
      bus.wf_req[0] = 1'b1; bus.wf_req[5] = 1'b1; bus.wf_req[39] = 1'b1;
      bus.decode_ready = 1'b1;
      exp_q.push_back(0); exp_q.push_back(5); exp_q.push_back(39);
      next_cycle();
      check("t1_valid", 64'(bus.arb_valid), 64'd1);
      check("t1_wfid0", 64'(bus.arb_wfid), 64'd0);
      next_cycle();
      check("t1_wfid5", 64'(bus.arb_wfid), 64'd5);
      next_cycle();
      check("t1_wfid39", 64'(bus.arb_wfid), 64'd39);
      next_cycle();
      check("t1_idle", 64'(bus.arb_valid), 64'd0);
      m = '0; m[0] = 1'b1; m[5] = 1'b1; m[39] = 1'b1;
      check("t1_inflight", 64'(bus.inflight_mask), 64'(m));
      check_drained("t1_drained");

      // All requesters, each released two cycles after its pop; wraps after 39.
      do_reset();
      bus.wf_req = '1;
      bus.decode_ready = 1'b1;
      for (int g = 0; g < 45; g++) exp_q.push_back(g % 40);
      for (int c = 0; c <= 46; c++) begin
         bus.release_en   = (c >= 3);
         bus.release_wfid = (c >= 3) ? WfidW'((c - 3) % 40) : '0;
         if (c == 45) bus.wf_req = '0;
         if (c >= 1 && c <= 45) check("t2_rr_wfid", 64'(bus.arb_wfid), 64'((c - 1) % 40));
         next_cycle();
      end
      check("t2_idle", 64'(bus.arb_valid), 64'd0);
      check_drained("t2_drained");

      // Backpressure hold on wf7, then pointer continues after 7.
      do_reset();
      bus.wf_req[7] = 1'b1;
      next_cycle();
      for (int k = 0; k < 4; k++) begin
         check("t3_hold_wfid", 64'(bus.arb_wfid), 64'd7);
         check("t3_hold_pop", 64'(bus.wf_pop), 64'd0);
         next_cycle();
      end
      check("t3_hold_valid", 64'(bus.arb_valid), 64'd1);
      check("t3_stall", 64'(bus.stall_cnt), StallEn ? 64'd4 : 64'd0);
      bus.wf_req = '0; bus.wf_req[6] = 1'b1; bus.wf_req[8] = 1'b1;
      bus.decode_ready = 1'b1;
      exp_q.push_back(7); exp_q.push_back(8); exp_q.push_back(6);
      #1;
      m = '0; m[7] = 1'b1;
      check("t3_pop7", 64'(bus.wf_pop), 64'(m));
      next_cycle();
      check("t3_next8", 64'(bus.arb_wfid), 64'd8);
      next_cycle();
      check("t3_next6", 64'(bus.arb_wfid), 64'd6);
      bus.wf_req = '0;
      next_cycle();
      check("t3_idle", 64'(bus.arb_valid), 64'd0);
      check_drained("t3_drained");

      // Recovery squash of the presented wfid.
      do_reset();
      bus.wf_req[12] = 1'b1;
      next_cycle();
      check("t4_wfid12", 64'(bus.arb_wfid), 64'd12);
      bus.wf_req[13] = 1'b1;
      bus.issue_recover_en = 1'b1; bus.issue_recover_wfid = 6'd12;
      #1;
      check("t4_squash_pop", 64'(bus.wf_pop), 64'd0);
      next_cycle();
      check("t4_wfid13", 64'(bus.arb_wfid), 64'd13);
      m = '0; m[13] = 1'b1;
      check("t4_inflight", 64'(bus.inflight_mask), 64'(m));
      bus.decode_ready = 1'b1; bus.issue_recover_wfid = 6'd13;
      #1;
      check("t4_squash_ready", 64'(bus.wf_pop), 64'd0);
      next_cycle();
      check("t4_regrant12", 64'(bus.arb_wfid), 64'd12);
      bus.issue_recover_en = 1'b0;
      exp_q.push_back(12); exp_q.push_back(13);
      next_cycle();
      check("t4_regrant13", 64'(bus.arb_wfid), 64'd13);
      bus.wf_req = '0;
      next_cycle();
      check("t4_idle", 64'(bus.arb_valid), 64'd0);
      m = '0; m[12] = 1'b1; m[13] = 1'b1;
      check("t4_inflight_end", 64'(bus.inflight_mask), 64'(m));
      check_drained("t4_drained");

      // Release and re-grant of wf3; out-of-range release ignored.
      do_reset();
      bus.wf_req[3] = 1'b1; bus.decode_ready = 1'b1;
      exp_q.push_back(3); exp_q.push_back(3);
      next_cycle();
      check("t5_wfid3", 64'(bus.arb_wfid), 64'd3);
      next_cycle();
      check("t5_blocked", 64'(bus.arb_valid), 64'd0);
      bus.release_en = 1'b1; bus.release_wfid = 6'd3;
      next_cycle();
      bus.release_en = 1'b0;
      check("t5_cleared", 64'(bus.inflight_mask), 64'd0);
      check("t5_not_yet", 64'(bus.arb_valid), 64'd0);
      next_cycle();
      check("t5_regrant", 64'(bus.arb_wfid), 64'd3);
      check("t5_regrant_v", 64'(bus.arb_valid), 64'd1);
      bus.wf_req = '0;
      bus.release_en = 1'b1; bus.release_wfid = 6'd45;
      next_cycle();
      bus.release_en = 1'b0;
      m = '0; m[3] = 1'b1;
      check("t5_oor_release", 64'(bus.inflight_mask), 64'(m));
      check_drained("t5_drained");

      // Asynchronous reset mid-stream.
      do_reset();
      bus.wf_req[2] = 1'b1; bus.wf_req[10] = 1'b1;
      repeat (10) next_cycle();
      check("t6_pre_valid", 64'(bus.arb_valid), 64'd1);
      check("t6_pre_stall", 64'(bus.stall_cnt), StallEn ? 64'd9 : 64'd0);
      #2;
      rst = 1'b0;
      #1;
      check("t6_async_valid", 64'(bus.arb_valid), 64'd0);
      check("t6_async_inflight", 64'(bus.inflight_mask), 64'd0);
      check("t6_async_stall", 64'(bus.stall_cnt), 64'd0);
      bus.decode_ready = 1'b1;
      #1;
      check("t6_rst_pop", 64'(bus.wf_pop), 64'd0);
      exp_q.push_back(2); exp_q.push_back(10);
      @(negedge clk);
      rst = 1'b1;
      next_cycle();
      check("t6_first", 64'(bus.arb_wfid), 64'd2);
      next_cycle();
      check("t6_second", 64'(bus.arb_wfid), 64'd10);
      bus.wf_req = '0;
      next_cycle();
      check("t6_idle", 64'(bus.arb_valid), 64'd0);
      check_drained("t6_drained");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
